// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a one-cycle blanking gap between digits
// and a frame snapshot taken on each 3->0 wrap. Optional leading-zero blanking: SEG_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_out,
  input  logic [15:0] value,
  input  logic        neg,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        frame_start
);

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  localparam logic [3:0] ANODE_OFF = ANODE_ACTIVE_LOW ? 4'b1111 : 4'b0000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  state_t      state;
  logic [1:0]  idx;
  logic        clk_out_q;
  logic        tick;
  logic [15:0] frame_value;
  logic        frame_neg;
  logic [3:0]  cur_digit;
  logic [3:0]  one_hot;
  logic [3:0]  anode_on;
  logic [6:0]  next_seg;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    case (d)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // clk_out is treated as data: a rising edge is seen as high now, low last cycle.
  assign tick = clk_out & ~clk_out_q;

  assign cur_digit = frame_value[{idx, 2'b00} +: 4];
  assign one_hot   = 4'b0001 << idx;
  assign anode_on  = ANODE_ACTIVE_LOW ? ~one_hot : one_hot;

`ifdef SEG_ZERO_BLANK_EN
  logic [3:0] dig_zero;
  logic [3:0] blank;

  // A digit blanks only if it and every higher digit are zero; a minus sign in
  // digit 3 takes that digit out of the chain.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dig_zero[i] = (frame_value[4*i +: 4] == 4'h0);
    end
    blank[3] = dig_zero[3] & ~frame_neg;
    blank[2] = dig_zero[2] & (frame_neg | dig_zero[3]);
    blank[1] = dig_zero[1] & blank[2];
    blank[0] = 1'b0;
  end
`endif

  // NOTE: combinational blocks assign a default first so no path leaves next_seg unassigned (no latch).
  always_comb begin
    next_seg = hex_to_seg(cur_digit);
    if (frame_neg && (idx == 2'd3)) begin
      next_seg = SEG_MINUS;
    end
`ifdef SEG_ZERO_BLANK_EN
    else if (blank[idx]) begin
      next_seg = SEG_BLANK;
    end
`endif
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the frame register is reset so digits before the first wrap show a defined zero frame.
      clk_out_q   <= 1'b1;
      state       <= SHOW;
      idx         <= 2'd0;
      anode       <= ANODE_OFF;
      seg         <= SEG_BLANK;
      frame_value <= 16'h0000;
      frame_neg   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      clk_out_q   <= clk_out;
      frame_start <= 1'b0;
      case (state)
        SHOW: begin
          if (tick) begin
            state <= GAP;
            idx   <= idx + 2'd1;
            anode <= ANODE_OFF;
            seg   <= SEG_BLANK;
            if (idx == 2'd3) begin
              frame_value <= value;
              frame_neg   <= neg;
              frame_start <= 1'b1;
            end
          end
        end
        GAP: begin
          // idx and the frame were already updated on the tick edge.
          state <= SHOW;
          anode <= anode_on;
          seg   <= next_seg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (default anode polarity, active-low).
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        clk_out;
  logic [15:0] value;
  logic        neg;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_2     = 7'b0100100;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_A     = 7'b0001000;
  localparam logic [6:0] S_F     = 7'b0001110;
  localparam logic [6:0] S_MINUS = 7'b0111111;
  localparam logic [6:0] S_BLANK = 7'b1111111;
`ifdef SEG_ZERO_BLANK_EN
  localparam logic [6:0] S_LEAD0 = 7'b1111111;
`else
  localparam logic [6:0] S_LEAD0 = 7'b1000000;
`endif

  seg_scan_driver dut (
    .clk         (clk),
    .rst         (rst),
    .clk_out     (clk_out),
    .value       (value),
    .neg         (neg),
    .anode       (anode),
    .seg         (seg),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk_out pulse: gap cycle after the first edge, new digit after the second.
  task automatic scan_step(input string tag, input logic [3:0] exp_an,
                           input logic [6:0] exp_seg, input logic exp_fs);
    clk_out = 1'b1;
    @(posedge clk); #1;
    check({tag, " gap anode"}, anode, 4'b1111);
    check({tag, " frame_start"}, frame_start, exp_fs);
    clk_out = 1'b0;
    @(posedge clk); #1;
    check({tag, " anode"}, anode, exp_an);
    check({tag, " seg"}, seg, exp_seg);
    check({tag, " frame_start low"}, frame_start, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    clk_out = 1'b1;
    value   = 16'h12AF;
    neg     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset anode", anode, 4'b1111);
    check("reset seg", seg, S_BLANK);
    check("reset frame_start", frame_start, 1'b0);

    // clk_out held high through release must not tick.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post-reset no tick anode", anode, 4'b1111);
    end
    clk_out = 1'b0;
    @(posedge clk); #1;
    check("clk_out low anode", anode, 4'b1111);

    // Zero frame for the first partial scan, then 12AF.
    scan_step("f0 d1", 4'b1101, S_LEAD0, 1'b0);
    scan_step("f0 d2", 4'b1011, S_LEAD0, 1'b0);
    scan_step("f0 d3", 4'b0111, S_LEAD0, 1'b0);
    scan_step("12AF d0", 4'b1110, S_F, 1'b1);
    scan_step("12AF d1", 4'b1101, S_A, 1'b0);
    scan_step("12AF d2", 4'b1011, S_2, 1'b0);
    scan_step("12AF d3", 4'b0111, S_1, 1'b0);

    // Mid-frame value change must not tear the current frame.
    value = 16'h1111;
    scan_step("1111 d0", 4'b1110, S_1, 1'b1);
    scan_step("1111 d1", 4'b1101, S_1, 1'b0);
    value = 16'h2222;
    scan_step("tear d2", 4'b1011, S_1, 1'b0);
    scan_step("tear d3", 4'b0111, S_1, 1'b0);
    scan_step("2222 d0", 4'b1110, S_2, 1'b1);
    scan_step("2222 d1", 4'b1101, S_2, 1'b0);

    // Negative frame.
    value = 16'h0005;
    neg   = 1'b1;
    scan_step("2222 d2", 4'b1011, S_2, 1'b0);
    scan_step("2222 d3", 4'b0111, S_2, 1'b0);
    scan_step("neg d0", 4'b1110, S_5, 1'b1);
    scan_step("neg d1", 4'b1101, S_LEAD0, 1'b0);
    scan_step("neg d2", 4'b1011, S_LEAD0, 1'b0);
    scan_step("neg d3", 4'b0111, S_MINUS, 1'b0);

    // Frozen clk_out holds the current digit.
    repeat (20) @(posedge clk);
    #1;
    check("freeze anode", anode, 4'b0111);
    check("freeze seg", seg, S_MINUS);

    // clk_out toggling every cycle: 8 ticks over 16 cycles, never two digits lit.
    for (int i = 0; i < 16; i++) begin
      clk_out = (i % 2 == 0);
      @(posedge clk); #1;
      check("toggle one-hot", ($countones(~anode) <= 1), 1'b1);
      check("toggle gap/show", anode, (i % 2 == 0) ? 4'b1111 : anode_for(((i / 2) + 4) % 4));
    end
    check("toggle end anode", anode, 4'b0111);
    check("toggle end seg", seg, S_MINUS);

    // Reset while in GAP with idx=2.
    scan_step("pre-rst d0", 4'b1110, S_5, 1'b1);
    scan_step("pre-rst d1", 4'b1101, S_LEAD0, 1'b0);
    clk_out = 1'b1;
    @(posedge clk); #1;
    check("gap before rst anode", anode, 4'b1111);
    rst     = 1'b1;
    clk_out = 1'b0;
    @(posedge clk); #1;
    check("gap rst anode", anode, 4'b1111);
    check("gap rst seg", seg, S_BLANK);
    check("gap rst frame_start", frame_start, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after rst anode", anode, 4'b1111);
    scan_step("rst f0 d1", 4'b1101, S_LEAD0, 1'b0);
    scan_step("rst f0 d2", 4'b1011, S_LEAD0, 1'b0);
    scan_step("rst f0 d3", 4'b0111, S_LEAD0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Active-low anode pattern for digit d.
  function automatic logic [3:0] anode_for(input int d);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    return ~oh;
  endfunction

endmodule
